// File: rtl/loader_pkg.sv
// Shared definitions for the program-ROM loader: memory geometry, default sync byte
// and the loader state encoding.
package loader_pkg;

   localparam int ROM_AW = 12;
   localparam int ROM_DW = 8;

   localparam logic [ROM_DW-1:0] DEFAULT_SYNC = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA,
      CSUM,
      DONE,
      ERR
   } loader_state_t;

endpackage

// File: rtl/rom_loader.sv
// Program-ROM loader: writes a SYNC/length framed byte stream into ROM from address 0
// and holds the CPU in reset until a complete image is in place.
// Define LOADER_CSUM_EN to add the trailing modulo-256 checksum byte and the ERR outcome.
module rom_loader
   import loader_pkg::*;
#(
   parameter logic [ROM_DW-1:0] SYNC = DEFAULT_SYNC
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              byte_valid,
   input  logic [ROM_DW-1:0] byte_data,
   output logic              byte_ready,
   input  logic              load_req,
   output logic              wr_en,
   output logic [ROM_AW-1:0] wr_addr,
   output logic [ROM_DW-1:0] wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   loader_state_t     state_q, state_d;
   logic [ROM_AW-1:0] len_q, len_d;
   logic [ROM_AW-1:0] cnt_q, cnt_d;
   logic              wr_en_q, wr_en_d;
   logic [ROM_AW-1:0] wr_addr_q, wr_addr_d;
   logic [ROM_DW-1:0] wr_data_q, wr_data_d;
   logic              accept;

`ifdef LOADER_CSUM_EN
   logic [ROM_DW-1:0] acc_q, acc_d;
   logic [ROM_DW-1:0] acc_sum;

   assign acc_sum = acc_q + byte_data;
`endif

   // Ready depends on state alone so the source never sees a valid->ready loop.
   assign byte_ready = (state_q == IDLE)   || (state_q == LEN_HI) ||
                       (state_q == LEN_LO) || (state_q == DATA)   ||
                       (state_q == CSUM);
   assign accept     = byte_valid && byte_ready;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
`ifdef LOADER_CSUM_EN
      acc_d     = acc_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (accept && (byte_data == SYNC)) begin
               state_d = LEN_HI;
            end
         end

         LEN_HI: begin
            if (accept) begin
               len_d[ROM_AW-1:8] = byte_data[3:0];
               cnt_d             = '0;
`ifdef LOADER_CSUM_EN
               acc_d             = '0;
`endif
               state_d           = LEN_LO;
            end
         end

         LEN_LO: begin
            if (accept) begin
               len_d[7:0] = byte_data;
               state_d    = DATA;
            end
         end

         // len holds the last address, so the frame carries len+1 bytes.
         DATA: begin
            if (accept) begin
               wr_en_d   = 1'b1;
               wr_addr_d = cnt_q;
               wr_data_d = byte_data;
               cnt_d     = cnt_q + 12'd1;
`ifdef LOADER_CSUM_EN
               acc_d     = acc_sum;
               if (cnt_q == len_q) begin
                  state_d = CSUM;
               end
`else
               if (cnt_q == len_q) begin
                  state_d = DONE;
               end
`endif
            end
         end

`ifdef LOADER_CSUM_EN
         CSUM: begin
            if (accept) begin
               state_d = (acc_sum == 8'h00) ? DONE : ERR;
            end
         end
`endif

         DONE, ERR: begin
            if (load_req) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
`ifdef LOADER_CSUM_EN
         acc_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
`ifdef LOADER_CSUM_EN
         acc_q     <= acc_d;
`endif
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign done     = (state_q == DONE);
   assign cpu_hold = (state_q != DONE);
`ifdef LOADER_CSUM_EN
   assign error    = (state_q == ERR);
`else
   assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: directed frames plus randomized framed streams,
// compared against a frame-level model of what the ROM should receive.
module tb_rom_loader;

   logic        clock = 1'b0;
   logic        reset;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        load_req;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [7:0]  wr_data;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int pass_count  = 0;
   int check_count = 0;

   logic [7:0]  frame_data[$];
   logic [7:0]  garbage_data[$];
   logic [7:0]  tx_stream[$];
   logic [19:0] exp_wr[$];
   logic [19:0] seen_wr[$];

   always #5 clock = ~clock;

   rom_loader #(.SYNC(8'hA5)) dut (
      .clock      (clock),
      .reset      (reset),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .load_req   (load_req),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error)
   );

   // Record every ROM write mid-cycle; each strobe lasts exactly one cycle.
   always @(negedge clock) begin
      if (reset === 1'b1 && wr_en === 1'b1) begin
         seen_wr.push_back({wr_addr, wr_data});
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Offers one byte until the loader takes it; optionally pulses load_req alongside it.
   task automatic sendByte(input logic [7:0] b, input bit noise);
      bit taken;
      taken      = 1'b0;
      byte_valid = 1'b1;
      byte_data  = b;
      for (int i = 0; i < 16 && !taken; i++) begin
         taken    = byte_ready;
         load_req = noise && ($urandom_range(0, 3) == 0);
         @(posedge clock);
         #1;
         load_req = 1'b0;
      end
      byte_valid = 1'b0;
      if (!taken) begin
         checkOutput("byte_accept", 32'd0, 32'd1);
      end
   endtask

   // Frame-level model: skip to the sync byte, read the length, and list the writes
   // and the final outcome that the byte stream should produce.
   task automatic predictFrame(output bit exp_done, output bit exp_err);
      int p;
      int n;
      int sum;
      p   = 0;
      sum = 0;
      exp_wr.delete();
      while (tx_stream[p] != 8'hA5) p++;
      n = (int'(tx_stream[p+1] % 16) * 256) + int'(tx_stream[p+2]) + 1;
      for (int k = 0; k < n; k++) begin
         exp_wr.push_back({12'(k), tx_stream[p+3+k]});
         sum = sum + int'(tx_stream[p+3+k]);
      end
`ifdef LOADER_CSUM_EN
      sum      = sum + int'(tx_stream[p+3+n]);
      exp_done = ((sum % 256) == 0);
      exp_err  = !exp_done;
`else
      exp_done = 1'b1;
      exp_err  = 1'b0;
`endif
   endtask

   task automatic applyStimulus(input logic [3:0] hi_junk, input bit use_fixed, input logic [7:0] fixed_csum,
                                input bit corrupt, input int gap_max, input bit noise);
      logic [11:0] len;
      logic [7:0]  sum;
      bit          exp_done;
      bit          exp_err;
      int          last;
      len = 12'(frame_data.size() - 1);
      sum = 8'h00;
      tx_stream.delete();
      seen_wr.delete();
      foreach (garbage_data[i]) tx_stream.push_back(garbage_data[i]);
      tx_stream.push_back(8'hA5);
      tx_stream.push_back({hi_junk, len[11:8]});
      tx_stream.push_back(len[7:0]);
      foreach (frame_data[i]) begin
         tx_stream.push_back(frame_data[i]);
         sum = sum + frame_data[i];
      end
`ifdef LOADER_CSUM_EN
      if (use_fixed)    tx_stream.push_back(fixed_csum);
      else if (corrupt) tx_stream.push_back(8'(-int'(sum) + int'($urandom_range(1, 255))));
      else              tx_stream.push_back(8'(-int'(sum)));
`else
      if (use_fixed && corrupt) $display("[TB] checksum byte %0h not sent in this build", fixed_csum);
`endif
      predictFrame(exp_done, exp_err);
      last = tx_stream.size() - 1;

      for (int i = 0; i <= last; i++) begin
         if (i == last) begin
            checkOutput("done_before_last", done, 0);
            checkOutput("hold_before_last", cpu_hold, 1);
         end
         sendByte(tx_stream[i], noise);
         if (gap_max > 0 && i != last) idleCycles($urandom_range(0, gap_max));
      end

      checkOutput("done_at_end", done, exp_done);
      checkOutput("error_at_end", error, exp_err);
      checkOutput("hold_at_end", cpu_hold, !exp_done);
      checkOutput("ready_at_end", byte_ready, 0);
`ifdef LOADER_CSUM_EN
      checkOutput("wr_en_after_csum", wr_en, 0);
`else
      checkOutput("last_write_with_done", {wr_en, wr_addr}, {1'b1, len});
`endif

      idleCycles(2);
      checkOutput("write_count", seen_wr.size(), exp_wr.size());
      for (int k = 0; k < exp_wr.size() && k < seen_wr.size(); k++) begin
         checkOutput("write", seen_wr[k], exp_wr[k]);
      end
      checkOutput("done_held", done, exp_done);

      load_req = 1'b1;
      @(posedge clock);
      #1;
      load_req = 1'b0;
      checkOutput("rearm_done", done, 0);
      checkOutput("rearm_error", error, 0);
      checkOutput("rearm_hold", cpu_hold, 1);
      checkOutput("rearm_ready", byte_ready, 1);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_wr_en"}, wr_en, 0);
      checkOutput({tag, "_wr_addr"}, wr_addr, 0);
      checkOutput({tag, "_wr_data"}, wr_data, 0);
      checkOutput({tag, "_ready"}, byte_ready, 1);
      checkOutput({tag, "_hold"}, cpu_hold, 1);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_error"}, error, 0);
   endtask

   initial begin
      reset      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      load_req   = 1'b0;
      #12;
      checkResetValues("reset");
      reset = 1'b1;
      idleCycles(1);

      $display("[TB] basic load");
      garbage_data.delete();
      frame_data = '{8'h11, 8'h22, 8'h33};
      applyStimulus(4'h0, 1'b0, 8'h00, 1'b0, 0, 1'b0);

`ifdef LOADER_CSUM_EN
      $display("[TB] bad checksum");
      frame_data = '{8'h11, 8'h22, 8'h33};
      applyStimulus(4'h0, 1'b1, 8'hCD, 1'b0, 0, 1'b0);
`endif

      $display("[TB] pre-sync garbage, one-byte frame");
      garbage_data = '{8'h00, 8'hFF, 8'h5A};
      frame_data   = '{8'h7E};
      applyStimulus(4'hF, 1'b0, 8'h00, 1'b0, 0, 1'b0);

      $display("[TB] single byte 42");
      garbage_data.delete();
      frame_data = '{8'h42};
      applyStimulus(4'h0, 1'b0, 8'h00, 1'b0, 0, 1'b0);

      $display("[TB] reset mid-frame");
      sendByte(8'hA5, 1'b0);
      sendByte(8'h00, 1'b0);
      sendByte(8'h02, 1'b0);
      sendByte(8'h11, 1'b0);
      sendByte(8'h22, 1'b0);
      reset = 1'b0;
      #1;
      checkResetValues("async_reset");
      @(negedge clock);
      reset = 1'b1;
      idleCycles(1);
      frame_data = '{8'h33, 8'h44, 8'h55};
      applyStimulus(4'h0, 1'b0, 8'h00, 1'b0, 0, 1'b0);

      $display("[TB] maximum size frame");
      frame_data.delete();
      for (int a = 0; a < 4096; a++) frame_data.push_back(8'(a));
      applyStimulus(4'h0, 1'b0, 8'h00, 1'b0, 0, 1'b0);

      $display("[TB] randomized frames");
      for (int f = 0; f < 25; f++) begin
         garbage_data.delete();
         frame_data.delete();
         repeat ($urandom_range(0, 3)) begin
            logic [7:0] g;
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h3C;
            garbage_data.push_back(g);
         end
         repeat ($urandom_range(1, 40)) begin
            if ($urandom_range(0, 3) == 0) frame_data.push_back(8'hA5);
            else                           frame_data.push_back(8'($urandom_range(0, 255)));
         end
         applyStimulus(4'($urandom_range(0, 15)), 1'b0, 8'h00, ($urandom_range(0, 3) == 0), 2, 1'b1);
      end

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
